// File: rtl/dac7611_frame_scheduler.sv
// dac7611_frame_scheduler
//
// Arbitrates 12-bit code updates from two requesters (round-robin on ties)
// and serialises the granted code MSB-first onto the DAC7611 3-wire pins,
// followed by a 4-cycle load strobe and a programmable idle gap.
//
// Ports:
//   clk_X4      system clock (4x DAC serial clock), rising edge
//   rst         synchronous active-high reset
//   enable      permits new grants; a frame in flight always completes
//   req0/data0  requester 0 level request and 12-bit code
//   req1/data1  requester 1 level request and 12-bit code
//   ack0/ack1   one-cycle grant pulses (data captured on the grant edge)
//   busy        high during SHIFT, LOAD and GAP
//   frame_done  one-cycle pulse as the load strobe ends
//   last_code   code of the most recently completed frame
//   CLK_3       DAC serial clock pin
//   SDI_4       DAC serial data pin
//   LD_5        DAC load strobe pin, active low
module dac7611_frame_scheduler #(
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk_X4,
    input  logic        rst,
    input  logic        enable,
    input  logic        req0,
    input  logic [11:0] data0,
    input  logic        req1,
    input  logic [11:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        busy,
    output logic        frame_done,
    output logic [11:0] last_code,
    output logic        CLK_3,
    output logic        SDI_4,
    output logic        LD_5
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD, S_GAP} state_t;

    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [7:0]  gap_cnt, gap_cnt_nxt;
    logic [11:0] shreg, shreg_nxt;
    logic        prio;      // 1: requester 1 wins a tie
    logic        grant;
    logic        win;       // granted requester index
    logic        load_end;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gap_cnt_nxt = gap_cnt;
        shreg_nxt   = shreg;
        grant       = 1'b0;
        win         = 1'b0;
        load_end    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && (req0 || req1)) begin
                    grant     = 1'b1;
                    win       = (req0 && req1) ? prio : req1;
                    shreg_nxt = win ? data1 : data0;
                    state_nxt = S_SHIFT;
                    cnt_nxt   = 6'd0;
                end
            end
            S_SHIFT: begin
                // Rotate rather than shift: after 12 slots the register
                // holds the original code again, which feeds last_code.
                if (cnt[1:0] == 2'd3)
                    shreg_nxt = {shreg[10:0], shreg[11]};
                if (cnt == 6'd47) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = 6'd0;
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            S_LOAD: begin
                if (cnt == 6'd3) begin
                    load_end = 1'b1;
                    cnt_nxt  = 6'd0;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = 8'd0;
                    end
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = S_IDLE;
                else
                    gap_cnt_nxt = gap_cnt + 8'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pins are registered from the next-state decode so they change on the
    // same edge as the state they belong to.
    always_ff @(posedge clk_X4) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 6'd0;
            gap_cnt    <= 8'd0;
            shreg      <= 12'd0;
            prio       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            last_code  <= 12'd0;
            CLK_3      <= 1'b1;
            SDI_4      <= 1'b0;
            LD_5       <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            shreg      <= shreg_nxt;
            if (grant)
                prio <= ~win;
            ack0       <= grant & ~win;
            ack1       <= grant & win;
            busy       <= (state_nxt != S_IDLE);
            frame_done <= load_end;
            if (load_end)
                last_code <= shreg;
            CLK_3      <= (state_nxt == S_SHIFT) ? cnt_nxt[1] : 1'b1;
            SDI_4      <= (state_nxt == S_SHIFT) & shreg_nxt[11];
            LD_5       <= (state_nxt != S_LOAD);
        end
    end

endmodule

// File: tb/tb_dac7611_frame_scheduler.sv
// Scoreboard bench for dac7611_frame_scheduler. A driver issues directed and
// random requests and a frame-level model predicts each grant (who, code,
// edge); a monitor pops predictions on ack and checks every cycle's pins
// against the ideal DAC waveform. A second instance with GAP_CYCLES=0 runs
// back-to-back frames and checks period and busy spacing.
module tb_dac7611_frame_scheduler;

    localparam int GAP = 8;

    logic clk_X4 = 1'b0;
    always #5 clk_X4 = ~clk_X4;

    logic        rst = 1'b1, enable = 1'b0, req0 = 1'b0, req1 = 1'b0;
    logic [11:0] data0 = 12'd0, data1 = 12'd0;
    logic        ack0, ack1, busy, frame_done, CLK_3, SDI_4, LD_5;
    logic [11:0] last_code;

    dac7611_frame_scheduler #(.GAP_CYCLES(GAP)) u_dut (
        .clk_X4(clk_X4), .rst(rst), .enable(enable),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .frame_done(frame_done),
        .last_code(last_code), .CLK_3(CLK_3), .SDI_4(SDI_4), .LD_5(LD_5)
    );

    logic        rst_z = 1'b1;
    logic [11:0] data_z = 12'h5A3;
    logic        ack0_z, ack1_z, busy_z, frame_done_z, CLK_3_z, SDI_4_z, LD_5_z;
    logic [11:0] last_code_z;

    dac7611_frame_scheduler #(.GAP_CYCLES(0)) u_dut_z (
        .clk_X4(clk_X4), .rst(rst_z), .enable(1'b1),
        .req0(1'b1), .data0(data_z), .req1(1'b0), .data1(12'd0),
        .ack0(ack0_z), .ack1(ack1_z), .busy(busy_z), .frame_done(frame_done_z),
        .last_code(last_code_z), .CLK_3(CLK_3_z), .SDI_4(SDI_4_z), .LD_5(LD_5_z)
    );

    int checks = 0, failures = 0;
    int cyc = 0;                 // number of the most recent rising edge
    int last_rst_edge = -1;

    always @(posedge clk_X4) begin
        cyc <= cyc + 1;
        if (rst) last_rst_edge <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    typedef struct {
        bit          who;
        logic [11:0] code;
        int          e0;
    } frame_t;

    frame_t exp_q[$];

    // ---------------- model + driver ----------------
    bit hold0 = 0, hold1 = 0, rnd = 0;
    int next_ok = 0;
    bit last_win = 1'b1;   // so that req0 wins the first tie

    task automatic step();
        frame_t f;
        int k;
        bit d0, d1, keep;
        k = cyc + 1;
        if (rst) begin
            next_ok  = k + 1;
            last_win = 1'b1;
        end else if (k >= next_ok && enable && (req0 || req1)) begin
            f.who  = (req0 && req1) ? !last_win : req1;
            f.code = f.who ? data1 : data0;
            f.e0   = k;
            exp_q.push_back(f);
            last_win = f.who;
            next_ok  = k + 53 + GAP;
        end
        @(negedge clk_X4);
        d0 = 0; d1 = 0;
        keep = rnd ? ($urandom_range(0, 7) == 0) : hold0;
        if (ack0 && req0 && !keep) begin req0 = 1'b0; d0 = 1; end
        keep = rnd ? ($urandom_range(0, 7) == 0) : hold1;
        if (ack1 && req1 && !keep) begin req1 = 1'b0; d1 = 1; end
        if (rnd) begin
            if (!req0 && !d0 && $urandom_range(0, 15) == 0) begin req0 = 1'b1; data0 = 12'($urandom); end
            if (!req1 && !d1 && $urandom_range(0, 15) == 0) begin req1 = 1'b1; data1 = 12'($urandom); end
            enable = ($urandom_range(0, 15) != 0);
            rst    = ($urandom_range(0, 499) == 0);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // ---------------- main monitor ----------------
    frame_t      cur;
    bit          cur_valid = 0;
    logic [11:0] exp_last = 12'd0;

    always @(negedge clk_X4) begin : mon
        int   r;
        logic e_clk, e_sdi, e_ld, e_busy, e_fd;
        if (cyc == last_rst_edge) begin
            cur_valid = 0;
            exp_last  = 12'd0;
        end
        if (ack0 || ack1) begin
            if (exp_q.size() == 0) begin
                check("spurious_ack", {ack1, ack0}, 2'b00);
            end else begin
                cur = exp_q.pop_front();
                cur_valid = 1;
                check("ack_sel", {ack1, ack0}, cur.who ? 2'b10 : 2'b01);
                check("ack_cycle", cyc, cur.e0);
            end
        end else if (exp_q.size() != 0 && exp_q[0].e0 <= cyc) begin
            cur = exp_q.pop_front();
            cur_valid = 1;
            check("ack_missing", {ack1, ack0}, cur.who ? 2'b10 : 2'b01);
        end
        r = cur_valid ? (cyc - cur.e0) : 100000;
        if (r < 48) begin
            e_clk = ((r % 4) >= 2);
            e_sdi = cur.code[11 - r / 4];
            e_ld  = 1'b1;
        end else if (r < 52) begin
            e_clk = 1'b1; e_sdi = 1'b0; e_ld = 1'b0;
        end else begin
            e_clk = 1'b1; e_sdi = 1'b0; e_ld = 1'b1;
        end
        e_busy = (r <= 51 + GAP);
        e_fd   = (r == 52);
        if (r == 52) exp_last = cur.code;
        check("pins_clk_sdi_ld_busy_done", {CLK_3, SDI_4, LD_5, busy, frame_done},
              {e_clk, e_sdi, e_ld, e_busy, e_fd});
        check("last_code", last_code, exp_last);
    end

    // ---------------- zero-gap monitor ----------------
    int z_prev_ack = -1, z_idle = 0, z_frames = 0, z_ld_low = 0;
    bit z_prev_busy = 0;

    always @(negedge clk_X4) begin
        if (!rst_z) begin
            if (ack0_z) begin
                if (z_prev_ack >= 0) check("z_period", cyc - z_prev_ack, 53);
                z_prev_ack = cyc;
                z_frames++;
            end
            if (!LD_5_z) z_ld_low++;
            if (frame_done_z) begin
                check("z_ld_low_cycles", z_ld_low, 4);
                check("z_last_code", last_code_z, data_z);
                z_ld_low = 0;
            end
            if (busy_z && !z_prev_busy) begin
                if (z_frames >= 2) check("z_busy_low", z_idle, 1);
                z_idle = 0;
            end
            if (!busy_z) z_idle++;
            z_prev_busy = busy_z;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        run(3);
        rst = 1'b0; rst_z = 1'b0;

        // single request, 0xABC
        enable = 1'b1; data0 = 12'hABC; req0 = 1'b1;
        run(70);

        // contention: both held, grants must alternate every 61 cycles
        data0 = 12'h000; data1 = 12'hFFF;
        hold0 = 1; hold1 = 1; req0 = 1'b1; req1 = 1'b1;
        run(61 * 4 + 5);
        hold0 = 0; hold1 = 0;
        run(130);

        // late request arriving mid-frame
        data0 = 12'h123; req0 = 1'b1;
        run(10);
        data1 = 12'h456; req1 = 1'b1;
        run(130);

        // enable drop with a request still pending
        data0 = 12'h321; req0 = 1'b1; hold0 = 1;
        run(20);
        enable = 1'b0;
        run(100);
        enable = 1'b1;
        run(5);
        hold0 = 0;
        run(130);

        // mid-frame reset, then a tie must go to req0
        data0 = 12'h0F0; data1 = 12'hF0F;
        hold0 = 1; hold1 = 1; req0 = 1'b1; req1 = 1'b1;
        run(30);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(5);
        hold0 = 0; hold1 = 0;
        run(200);

        // random traffic
        rnd = 1;
        run(3000);
        rnd = 0; rst = 1'b0; enable = 1'b1;
        run(200);
        req0 = 1'b0; req1 = 1'b0;
        run(70);

        check("drain_queue_empty", exp_q.size(), 0);
        check("z_frames_seen", (z_frames >= 20), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
